// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the RGB PWM driver.
package led_pwm_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PHASE_MAX = 8'hFF;

  typedef logic [DUTY_W-1:0] duty_t;

  // Channel index used to address the per-colour arrays in the top level.
  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } led_ch_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM colour channel: target capture, boundary-gated duty update with
// optional one-step fade, and the phase/duty compare.
module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  duty_t x_in,
  input  duty_t phase,
  input  logic  bnd,
  input  logic  fade_en,
  input  logic  fade_step,
  output logic  pwm,
  output logic  differs
);

  duty_t tgt_q;
  duty_t act_q;
  duty_t act_d;
  logic  pwm_q;

  // Active duty moves only on a period boundary, so a running period never glitches.
  always_comb begin
    act_d = act_q;
    if (bnd && !fade_en) begin
      act_d = tgt_q;
    end else if (fade_step && (act_q != tgt_q)) begin
      // Only stepping while act != tgt keeps 0-1 and 255+1 out of reach.
      act_d = (act_q < tgt_q) ? act_q + 8'd1 : act_q - 8'd1;
    end
  end

  // Target capture, active duty and registered compare output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q <= '0;
      act_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= x_in;
      act_q <= act_d;
      pwm_q <= (phase < act_q);
    end
  end

  assign pwm     = pwm_q;
  assign differs = (act_q != tgt_q);

endmodule

// File: rtl/led_rgb_pwm.sv
// Three-channel PWM driver fed by the red/green/blue PIO intensity registers.
// Owns the shared prescaler, phase counter and fade divider.
module led_rgb_pwm
  import led_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 195,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic       fade_en,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       period_tick,
  output logic       busy
);

  localparam logic [15:0] PreMax  = 16'(PRESCALE - 1);
  localparam logic [7:0]  FcntMax = 8'(FADE_DIV - 1);

  logic [15:0] pre_q, pre_d;
  duty_t       phase_q, phase_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        tick_q;
  logic        busy_q;
  logic        step;
  logic        bnd;
  logic        fade_step;

  duty_t       ch_in [3];
  logic  [2:0] ch_pwm;
  logic  [2:0] ch_differs;

  assign step      = (pre_q == PreMax);
  assign bnd       = step && (phase_q == PHASE_MAX);
  assign fade_step = bnd && fade_en && (fcnt_q == FcntMax);

  // Prescaler, phase and fade-divider next state; fade_en only matters at a boundary.
  always_comb begin
    pre_d   = step ? 16'd0 : pre_q + 16'd1;
    phase_d = step ? phase_q + 8'd1 : phase_q;
    fcnt_d  = fcnt_q;
    if (bnd) begin
      if (!fade_en || (fcnt_q == FcntMax)) begin
        fcnt_d = 8'd0;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Timebase state plus registered period tick and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      phase_q <= '0;
      fcnt_q  <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      tick_q  <= bnd;
      busy_q  <= |ch_differs;
    end
  end

  assign ch_in[CH_R] = red_in;
  assign ch_in[CH_G] = green_in;
  assign ch_in[CH_B] = blue_in;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    led_pwm_channel u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .x_in      (ch_in[i]),
      .phase     (phase_q),
      .bnd       (bnd),
      .fade_en   (fade_en),
      .fade_step (fade_step),
      .pwm       (ch_pwm[i]),
      .differs   (ch_differs[i])
    );
  end

  assign pwm_r       = ch_pwm[CH_R];
  assign pwm_g       = ch_pwm[CH_G];
  assign pwm_b       = ch_pwm[CH_B];
  assign period_tick = tick_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_led_rgb_pwm.sv
// Directed bench for led_rgb_pwm with PRESCALE=1 (256-cycle period), FADE_DIV=2.
module tb_led_rgb_pwm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] red_in, green_in, blue_in;
  logic       fade_en;
  logic       pwm_r, pwm_g, pwm_b, period_tick, busy;

  int n_eval = 0;
  int n_fail = 0;

  led_rgb_pwm #(
    .PRESCALE (1),
    .FADE_DIV (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .fade_en     (fade_en),
    .pwm_r       (pwm_r),
    .pwm_g       (pwm_g),
    .pwm_b       (pwm_b),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge where period_tick is high (bounded).
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_tick !== 1'b1 && n < 600);
    check({tag, "/tick"}, {31'b0, period_tick}, 32'd1);
  endtask

  // Count release-to-first-tick negedges.
  task automatic first_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_tick !== 1'b1 && n < 600);
    check(tag, n, 256);
  endtask

  // Called on a tick negedge: sample the following 256 cycles (one full period of
  // registered pwm), count highs per channel and require each high run to be a
  // single run starting at the first sample. Optionally change green at sample chg_i.
  task automatic measure(input string tag, input int er, input int eg, input int eb,
                         input int chg_i, input logic [7:0] chg_v);
    int cr, cg, cb, bad;
    logic lr, lg, lb;
    cr = 0; cg = 0; cb = 0; bad = 0;
    lr = 1'b0; lg = 1'b0; lb = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_r === 1'b1) begin cr++; if (lr) bad++; end else lr = 1'b1;
      if (pwm_g === 1'b1) begin cg++; if (lg) bad++; end else lg = 1'b1;
      if (pwm_b === 1'b1) begin cb++; if (lb) bad++; end else lb = 1'b1;
      if (i == chg_i) green_in = chg_v;
    end
    check({tag, "/r_high"}, cr, er);
    check({tag, "/g_high"}, cg, eg);
    check({tag, "/b_high"}, cb, eb);
    check({tag, "/shape"}, bad, 0);
    check({tag, "/tick"}, {31'b0, period_tick}, 32'd1);
  endtask

  int fexp [7] = '{0, 0, 1, 1, 2, 2, 3};

  initial begin
    reset_n  = 1'b0;
    red_in   = 8'd0;
    green_in = 8'd0;
    blue_in  = 8'd0;
    fade_en  = 1'b0;
    #23;
    check("reset_outs", {27'b0, pwm_r, pwm_g, pwm_b, period_tick, busy}, 32'd0);

    // Idle after release: first tick 256 cycles out, outputs stay low.
    @(negedge clk);
    reset_n = 1'b1;
    first_tick("first_tick");
    measure("idle", 0, 0, 0, -1, 8'd0);

    // Duty accuracy.
    green_in = 8'd128;
    blue_in  = 8'd255;
    wait_tick("duty_w1");
    wait_tick("duty_w2");
    measure("duty_a", 0, 128, 255, -1, 8'd0);
    measure("duty_b", 0, 128, 255, -1, 8'd0);

    // Asynchronous reset mid-period drops outputs in the same cycle.
    @(negedge clk);
    check("pre_rst_b", {31'b0, pwm_b}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("midrst_outs", {27'b0, pwm_r, pwm_g, pwm_b, period_tick, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    first_tick("rel_tick");

    // Glitch-free update: 200 -> 10 changed at phase 50.
    green_in = 8'd200;
    wait_tick("g_w1");
    wait_tick("g_w2");
    measure("g_cur", 0, 200, 255, 49, 8'd10);
    check("g_busy_bnd", {31'b0, busy}, 32'd1);
    measure("g_next", 0, 10, 255, -1, 8'd0);
    check("g_busy_clr", {31'b0, busy}, 32'd0);

    // Fade blue 0 -> 3, one step every 2 boundaries.
    blue_in = 8'd0;
    wait_tick("f_w");
    fade_en = 1'b1;
    blue_in = 8'd3;
    for (int i = 0; i < 6; i++) measure($sformatf("fade%0d", i), 0, 10, fexp[i], -1, 8'd0);
    check("fade_busy_hi", {31'b0, busy}, 32'd1);
    measure("fade6", 0, 10, fexp[6], -1, 8'd0);
    check("fade_busy_lo", {31'b0, busy}, 32'd0);

    // Reversal mid-fade, then cancel.
    blue_in = 8'd6;
    measure("rev_a", 0, 10, 3, -1, 8'd0);
    measure("rev_b", 0, 10, 4, -1, 8'd0);
    blue_in = 8'd0;
    measure("rev_c", 0, 10, 4, -1, 8'd0);
    measure("rev_d", 0, 10, 3, -1, 8'd0);
    fade_en = 1'b0;
    measure("cancel_a", 0, 10, 3, -1, 8'd0);
    measure("cancel_b", 0, 10, 0, -1, 8'd0);

    // Extremes: 254 -> 255 and 1 -> 0, then hold without wrapping.
    red_in  = 8'd1;
    blue_in = 8'd254;
    wait_tick("x_w");
    fade_en = 1'b1;
    red_in  = 8'd0;
    blue_in = 8'd255;
    measure("ext_a", 1, 10, 254, -1, 8'd0);
    measure("ext_b", 1, 10, 254, -1, 8'd0);
    measure("ext_c", 0, 10, 255, -1, 8'd0);
    measure("ext_d", 0, 10, 255, -1, 8'd0);
    measure("ext_e", 0, 10, 255, -1, 8'd0);
    check("ext_busy", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/led_rgb_pwm.md
# led_rgb_pwm

Three-channel PWM driver sitting directly downstream of the red/green/blue Avalon PIO output ports. It consumes each port's 8-bit `out_port` intensity value and produces one PWM pin per LED colour. Duty updates take effect only on period boundaries, so the outputs never glitch. An optional linear fade slews each channel toward its new target by one step per N periods.

## Interface
Parameters:
- `PRESCALE`, default 195: clock cycles per PWM phase step, range 1..65535 (50 MHz / 256 / 195 ≈ 1 kHz PWM).
- `FADE_DIV`, default 4: PWM periods per fade step, range 1..255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous active-low reset.
- `red_in`  in  8  red intensity target, from the red PIO `out_port`.
- `green_in`  in  8  green intensity target, from the green PIO `out_port`.
- `blue_in`  in  8  blue intensity target, from the blue PIO `out_port`.
- `fade_en`  in  1  1 = slew toward target; 0 = jump to target.
- `pwm_r`, `pwm_g`, `pwm_b`  out  1 each  PWM outputs, active high.
- `period_tick`  out  1  one-cycle pulse at each PWM period boundary.
- `busy`  out  1  1 while any channel's active duty differs from its target.

## Operation
- Prescaler: 16-bit counter `pre`, 0..PRESCALE-1. `step` asserts when `pre == PRESCALE-1`; `pre` then wraps to 0.
- Phase: 8-bit counter `phase`, increments on `step` and wraps 255→0.
- Boundary: `bnd = step && phase == 255`. Registered `period_tick` equals `bnd` delayed one cycle.
- Target: `tgt_x` registers `x_in` every cycle, giving 1 cycle of latency. Inputs are static PIO registers, so no extra synchronisation is needed.
- Active duty `act_x` changes only on `bnd`:
  - `fade_en=0`: `act_x <= tgt_x`.
  - `fade_en=1`: the 8-bit `fcnt` counts boundaries 0..FADE_DIV-1. On the boundary where `fcnt == FADE_DIV-1`, `act_x` steps ±1 toward `tgt_x`; if they are equal, `act_x` holds. `fcnt` wraps to 0.
  - `fade_en=0` holds `fcnt` at 0.
  - All three channels share `fcnt` and step in the same cycle.
- Output: `pwm_x <= (phase < act_x)`, registered.
  - Duty 0 gives constant low.
  - Duty 255 gives high for 255 of every 256 phase steps.
  - Duty d gives exactly d high phase steps per period.
- Busy: registered, `busy <= |{act_r != tgt_r, act_g != tgt_g, act_b != tgt_b}`.
- Arithmetic: act ±1 never wraps. The step is taken only when act ≠ tgt, so 0−1 and 255+1 cannot occur.

## Timing
- Reset (async assert, sync release via `reset_n`):
  - `pre`, `phase`, `fcnt`, `tgt_*`, `act_*` = 0.
  - `pwm_*` = 0, `period_tick` = 0, `busy` = 0.
- After reset release, the first `bnd` occurs at cycle 256·PRESCALE−1.
- Input → active, `fade_en=0`: the new value is used from the first period after the next `bnd`. Worst-case latency is 256·PRESCALE+1 cycles.
- `pwm_x` lags the phase/act comparison by 1 cycle. `pwm_x` changes only on `step` cycles+1, or on the cycle after an `act` update.
- Target change mid-fade: the next step moves toward the new target. Direction is re-evaluated at every fade step.
- Toggling `fade_en`: sampled at `bnd` only.
  - 1→0: `act` jumps to `tgt` at the next `bnd`, and `fcnt` clears.
  - 0→1: the first fade step occurs FADE_DIV boundaries later.
- Input changes in the same cycle as `bnd`: the `act` update uses the old `tgt` (registered). The new value applies at the following boundary.
- Reset mid-period: all state clears immediately, and outputs go low asynchronously.

## Structure
- Shared package `led_pwm_pkg`:
  - `DUTY_W = 8`, `PHASE_MAX = 8'hFF`.
  - typedef `duty_t` (logic [7:0]).
  - enum `led_ch_e` {CH_R, CH_G, CH_B}.
- Sub-module `led_pwm_channel`, instantiated 3×.
  - Inputs: `clk`, `reset_n`, `x_in`, `phase`, `bnd`, `fade_en`, `fade_step`.
  - Contents: `tgt`/`act` registers, fade-step logic, compare.
  - Outputs: `pwm`, `differs`.
- Top level owns the prescaler, phase counter, fcnt, `period_tick` and the busy OR.

## Test plan
All scenarios use PRESCALE=1, so one period is 256 cycles.
- Reset/idle: assert `reset_n`=0 mid-run → all outputs 0 within the same cycle. After release with inputs 0, `pwm_*` stays 0 and `period_tick` pulses every 256 cycles.
- Duty accuracy: red=0, green=128, blue=255, `fade_en`=0 → after the second boundary, per period pwm_r high 0 cycles, pwm_g 128, pwm_b 255. Each high run is contiguous and starts at phase 0+1.
- Glitch-free update: change green 200→10 at phase 50 → the current period still shows 200 high cycles and the next shows 10. `busy`=1 only until that boundary.
- Fade: FADE_DIV=2, `fade_en`=1, blue 0→3 → act_b = 1, 2, 3 at boundaries 2, 4, 6. `busy` clears one cycle after act_b = 3.
- Fade reversal and cancel: mid-fade toward 3, set the target to 0 → next step decrements. Clear `fade_en` → act jumps to target at the next boundary.
- Extremes/no wrap: fade with target 255 from 254 and target 0 from 1 → single step, then holds. act never wraps past 255 or below 0.
